// File: rtl/tdo_shift_scheduler.sv
// Two-requester round-robin scheduler feeding an MSB-first serializer.
// state | meaning
// IDLE  | out=0, selecting a requester, accepting one word
// SHIFT | transfer owned; one bit per shift_en; abort returns to IDLE
// DONE  | one-cycle done pulse, last bit still on out, no accept
module tdo_shift_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             shift_en,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             grant_id
);

  localparam int RW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [RW-1:0]    remaining_q, remaining_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             sel;

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) sel = ~last_grant_q;
  end

  assign req0_ready = !reset && (state_q == IDLE) && !sel && req0_valid && !abort;
  assign req1_ready = !reset && (state_q == IDLE) &&  sel && req1_valid && !abort;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    remaining_d  = remaining_q;
    out_d        = out_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        out_d = 1'b0;
        if (req0_ready) begin
          shreg_d     = req0_data;
          grant_d     = 1'b0;
          remaining_d = RW'(WIDTH);
          state_d     = SHIFT;
        end else if (req1_ready) begin
          shreg_d     = req1_data;
          grant_d     = 1'b1;
          remaining_d = RW'(WIDTH);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          out_d        = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (shift_en) begin
          out_d   = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (remaining_q != '0) remaining_d = remaining_q - RW'(1);
          if (remaining_q == RW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        out_d        = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      remaining_q  <= '0;
      out_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      remaining_q  <= remaining_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_tdo_shift_scheduler.sv
// Bench for tdo_shift_scheduler: a 32-bit and an 8-bit instance driven in turn,
// checked against a transfer-level model of arbitration and serial output.
module tb_tdo_shift_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, sh, ab;
  logic [31:0] d0, d1;
  bit          use8;

  logic r0_32, r1_32, o_32, b_32, dn_32, g_32;
  logic r0_8, r1_8, o_8, b_8, dn_8, g_8;
  logic r0, r1, o, b, dn, gi;

  int vectors = 0;
  int miscompares = 0;

  bit last_g[2];
  bit gid[2];

  always #5 clk = ~clk;

  tdo_shift_scheduler #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst),
    .req0_valid(v0 & !use8), .req0_data(d0), .req0_ready(r0_32),
    .req1_valid(v1 & !use8), .req1_data(d1), .req1_ready(r1_32),
    .shift_en(sh & !use8), .abort(ab & !use8),
    .out(o_32), .busy(b_32), .done(dn_32), .grant_id(g_32)
  );

  tdo_shift_scheduler #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst),
    .req0_valid(v0 & use8), .req0_data(d0[7:0]), .req0_ready(r0_8),
    .req1_valid(v1 & use8), .req1_data(d1[7:0]), .req1_ready(r1_8),
    .shift_en(sh & use8), .abort(ab & use8),
    .out(o_8), .busy(b_8), .done(dn_8), .grant_id(g_8)
  );

  assign r0 = use8 ? r0_8 : r0_32;
  assign r1 = use8 ? r1_8 : r1_32;
  assign o  = use8 ? o_8  : o_32;
  assign b  = use8 ? b_8  : b_32;
  assign dn = use8 ? dn_8 : dn_32;
  assign gi = use8 ? g_8  : g_32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer starting in an IDLE cycle; returns at an IDLE cycle.
  task automatic xfer(input logic [31:0] a0, input logic [31:0] a1, input bit vi0, input bit vi1,
                      input int mode, input int abort_at, input int rst_at, input bit idle_ab);
    int u, w, n;
    bit g, en, da, dr;
    logic [31:0] dd;
    u = use8 ? 1 : 0;
    w = use8 ? 8 : 32;
    v0 = vi0; v1 = vi1; d0 = a0; d1 = a1;
    sh = 1'($urandom_range(0, 1));
    ab = idle_ab;
    if (idle_ab) begin
      @(negedge clk);
      chk("ready0_abort_idle", r0, 0);
      chk("ready1_abort_idle", r1, 0);
      step();
      ab = 1'b0;
    end
    g = (vi0 && vi1) ? !last_g[u] : vi1;
    @(negedge clk);
    chk("ready0", r0, vi0 && !g);
    chk("ready1", r1, vi1 && g);
    chk("idle_out", o, 0);
    chk("idle_busy", b, 0);
    chk("idle_done", dn, 0);
    chk("idle_grant", gi, gid[u]);
    dd = g ? a1 : a0;
    if (use8) dd = dd & 32'hFF;
    step();
    d0 = $urandom; d1 = $urandom;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      en = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      da = (abort_at >= 0) && (n == abort_at);
      dr = (rst_at >= 0) && (n == rst_at);
      sh = en; ab = da; rst = dr;
      @(negedge clk);
      chk("shift_busy", b, 1);
      chk("shift_done", dn, 0);
      chk("shift_out", o, (n == 0) ? 0 : dd[w-n]);
      chk("shift_grant", gi, g);
      chk("shift_ready0", r0, 0);
      chk("shift_ready1", r1, 0);
      step();
      if (dr || da) begin
        rst = 1'b0; ab = 1'b0; sh = 1'b0; v0 = 1'b0; v1 = 1'b0;
        if (dr) begin
          last_g[0] = 1; last_g[1] = 1; gid[0] = 0; gid[1] = 0;
        end else begin
          last_g[u] = g; gid[u] = g;
        end
        @(negedge clk);
        chk(dr ? "rst_busy" : "abort_busy", b, 0);
        chk(dr ? "rst_out" : "abort_out", o, 0);
        chk(dr ? "rst_done" : "abort_done", dn, 0);
        chk(dr ? "rst_grant" : "abort_grant", gi, gid[u]);
        step();
        return;
      end
      if (en) n++;
      if (n == w) break;
    end
    sh = 1'($urandom_range(0, 1));
    ab = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_pulse", dn, 1);
    chk("done_busy", b, 0);
    chk("done_out", o, dd[0]);
    chk("done_grant", gi, g);
    chk("done_ready0", r0, 0);
    chk("done_ready1", r1, 0);
    step();
    last_g[u] = g; gid[u] = g;
    sh = 1'b0; ab = 1'b0;
  endtask

  initial begin
    int w;
    bit a, bq, ia;
    int md, at;
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; sh = 1'b0; ab = 1'b0; use8 = 1'b0;
    d0 = 32'h0; d1 = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_ready0", r0, 0);
      chk("reset_ready1", r1, 0);
    end
    step();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    last_g[0] = 1; last_g[1] = 1; gid[0] = 0; gid[1] = 0;
    @(negedge clk);
    chk("reset_out", o, 0);
    chk("reset_busy", b, 0);
    chk("reset_done", dn, 0);
    chk("reset_grant", gi, 0);
    step();

    repeat (4) xfer(32'h11111111, 32'h22222222, 1, 1, 0, -1, -1, 0);
    xfer(32'hA5A50F0F, 32'h0, 1, 0, 0, -1, -1, 0);
    xfer($urandom, $urandom, 1, 1, 1, -1, -1, 0);
    xfer($urandom, $urandom, 0, 1, 0, 10, -1, 0);
    xfer($urandom, $urandom, 1, 1, 0, -1, -1, 0);
    xfer($urandom, $urandom, 1, 1, 0, -1, 5, 0);
    xfer($urandom, $urandom, 1, 1, 0, -1, -1, 0);

    for (int i = 0; i < 22; i++) begin
      if (i == 16) begin
        use8 = 1'b1;
        xfer(32'h0, 32'hFFFFFF81, 0, 1, 0, -1, -1, 0);
      end
      w = use8 ? 8 : 32;
      a = 1'($urandom_range(0, 1));
      bq = a ? 1'($urandom_range(0, 1)) : 1'b1;
      md = $urandom_range(0, 2);
      at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w - 1) : -1;
      ia = ($urandom_range(0, 3) == 0);
      xfer($urandom, $urandom, a, bq, md, at, -1, ia);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdo_shift_scheduler.md
TDO_SHIFT_SCHEDULER -- requirements
Module: tdo_shift_scheduler

Interface
REQ-001 Parameter: WIDTH, default 32, bits per transfer; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a word to send.
REQ-005 req0_data  input  WIDTH  requester 0 word.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 req1_valid, req1_data, req1_ready  same as REQ-004..006, for requester 1.
REQ-008 shift_en  input  1  advance the serializer by one bit this cycle.
REQ-009 abort  input  1  cancel the current transfer.
REQ-010 out  output  1  registered serial data, MSB first.
REQ-011 busy  output  1  a transfer is owned and shifting.
REQ-012 done  output  1  one-cycle pulse when a transfer completes.
REQ-013 grant_id  output  1  requester that owns the current or last transfer.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; state and all outputs except req*_ready are registered.
REQ-015 In IDLE, exactly one requester is selected as follows.
- If only one requester has valid high, select it.
- If both have valid high, select the requester that is not last_grant (round-robin).
REQ-016 reqN_ready is combinational: reqN_ready = (state==IDLE) && selected==N && reqN_valid && !abort.
- Both ready signals are never high in the same cycle.
REQ-017 On accept (valid && ready), the following happen.
- Capture reqN_data into the shift register.
- grant_id <= N.
- remaining <= WIDTH.
- Next state is SHIFT.
REQ-018 In SHIFT with shift_en=1 and abort=0, the serializer advances one bit.
- out <= shreg[WIDTH-1].
- shreg shifts left by one.
- remaining decrements by one.
REQ-019 In SHIFT with shift_en=0 and abort=0, out, shreg and remaining hold.
REQ-020 On the edge of the shift cycle where remaining==1, the next state is DONE.
- The last bit appears on out in the DONE cycle.
REQ-021 In DONE the block does the following, then goes to IDLE.
- done=1 and busy=0; out holds the last bit.
- Update last_grant <= grant_id.
- No accept is possible in DONE, so there is a minimum one-cycle gap between transfers.
REQ-022 busy=1 exactly while state==SHIFT.
REQ-023 out=0 in every IDLE cycle.
REQ-024 done is 0 in every state except DONE.
REQ-025 abort in SHIFT has priority over shift_en.
- Next state is IDLE and out <= 0.
- No done pulse is generated.
- last_grant <= grant_id, so the aborted requester counts as served.
REQ-026 abort in IDLE or DONE has no effect other than blocking ready (REQ-016).
REQ-027 Latency: accept at cycle T; the first bit is on out at T+1+k, where k is the index of the first shift_en cycle.
- With shift_en held high, bit i is on out at T+2+i.
- done is high at T+1+WIDTH.
REQ-028 Data on reqN_data is sampled only in the accept cycle; later changes do not affect the transfer in flight.
REQ-029 remaining is $clog2(WIDTH+1) bits wide and never wraps below 0.

Reset
REQ-030 With reset=1 at a rising edge, the next cycle has the following values.
- state=IDLE, out=0, busy=0, done=0, grant_id=0.
- last_grant=1, so requester 0 wins the first tie.
- shreg=0, remaining=0.
REQ-031 reset overrides abort, shift_en and any request.
- A transfer in progress is dropped with no done pulse.
REQ-032 While reset=1, req0_ready and req1_ready are 0.

Verification
REQ-033 Single transfer: req0 with data 0xA5A50F0F, shift_en held high.
- req0_ready is high for 1 cycle.
- out sequence is 1,0,1,0,0,1,0,1,... (32 bits, MSB first).
- done is high once, at accept+33.
- busy is high for 32 cycles.
REQ-034 Arbitration: both valid held high continuously from reset, with data 0x11111111 and 0x22222222.
- Grants go req0, req1, req0, req1.
- grant_id matches each transfer.
- There is exactly 1 IDLE cycle between the DONE of one transfer and the next accept.
REQ-035 Pacing: shift_en alternates 1,0 during SHIFT.
- out changes only after enabled cycles.
- done asserts after exactly 32 enabled cycles, at accept+64.
REQ-036 Abort: abort asserted after 10 bits of a req1 transfer.
- busy=0 and out=0 on the next cycle; no done pulse.
- With both valid next, req0 is granted.
REQ-037 Reset mid-shift: reset pulsed after 5 bits.
- All outputs take their REQ-030 values.
- With both valid afterwards, req0 is granted first.
REQ-038 WIDTH=8, data 0x81 on req1.
- out sequence is 1,0,0,0,0,0,0,1.
- done at accept+9.
- Upper data bits are ignored.
